// File: rtl/halt_pattern_gen_if.sv
// Control and status bundle between the test environment and halt_pattern_gen.
interface halt_pattern_gen_if #(
  parameter int CNT_W  = 8,
  parameter int STAT_W = 16
);
  logic              enable;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  run_len;
  logic [CNT_W-1:0]  halt_len;
  logic              clr_stats;
  logic              halt_b;
  logic              halt_start;
  logic              halt_end;
  logic              done;
  logic [STAT_W-1:0] halt_total;

  // Bench side: drives the controls, observes the halt waveform and stats.
  modport master (
    output enable, mode, run_len, halt_len, clr_stats,
    input  halt_b, halt_start, halt_end, done, halt_total
  );

  // Generator side.
  modport slave (
    input  enable, mode, run_len, halt_len, clr_stats,
    output halt_b, halt_start, halt_end, done, halt_total
  );
endinterface

// File: rtl/halt_pattern_gen.sv
// halt_pattern_gen: drives the active-low CPU halt line to emulate DMA bus
// steal. Modes: off, periodic run/halt, LFSR-masked random run length, and
// one-shot. Also emits halt edge strobes and a saturating halted-cycle count.
module halt_pattern_gen #(
  parameter int                CNT_W     = 8,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter int                STAT_W    = 16
) (
  input logic               clk,
  input logic               reset_b,
  halt_pattern_gen_if.slave bus
);

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400);

  typedef enum logic [1:0] {IDLE, RUN, HALT, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [1:0]        mode_q, mode_q_next;
  logic [LFSR_W-1:0] lfsr, lfsr_next;
  logic [CNT_W-1:0]  rand_run;
  logic              halt_b_next;

  logic              halt_b_q;
  logic              halt_start_q;
  logic              halt_end_q;
  logic              done_q;
  logic [STAT_W-1:0] halt_total_q;

  // The counter holds "cycles left minus one", so a zero length still gives
  // a one-cycle phase and expiry is simply cnt == 0.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  assign rand_run    = lfsr[CNT_W-1:0] & bus.run_len;
  assign lfsr_next   = bus.enable ? ((lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0)) : lfsr;
  assign halt_b_next = (state_next != HALT);

  // Next-state logic: phase sequencing, length loads and mode latching.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    mode_q_next = mode_q;
    if (!bus.enable) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.mode != 2'd0) begin
            state_next  = RUN;
            mode_q_next = bus.mode;
            cnt_next    = load_val((bus.mode == 2'd2) ? rand_run : bus.run_len);
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state_next  = HALT;
            mode_q_next = bus.mode;
            cnt_next    = load_val(bus.halt_len);
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        HALT: begin
          if (cnt == '0) begin
            unique case (mode_q)
              2'd0: state_next = IDLE;
              2'd3: state_next = DONE;
              default: begin
                state_next = RUN;
                cnt_next   = load_val((mode_q == 2'd2) ? rand_run : bus.run_len);
              end
            endcase
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, phase counter, latched mode and LFSR registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 2'd0;
      lfsr   <= LFSR_SEED;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      mode_q <= mode_q_next;
      lfsr   <= lfsr_next;
    end
  end

  // Registered outputs: halt line, its edge strobes, done flag and halt count.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      halt_b_q     <= 1'b1;
      halt_start_q <= 1'b0;
      halt_end_q   <= 1'b0;
      done_q       <= 1'b0;
      halt_total_q <= '0;
    end else begin
      halt_b_q     <= halt_b_next;
      halt_start_q <= halt_b_q & ~halt_b_next;
      halt_end_q   <= ~halt_b_q & halt_b_next;
      done_q       <= (state_next == DONE);
      if (bus.clr_stats) begin
        halt_total_q <= '0;
      end else if (!halt_b_q && (halt_total_q != '1)) begin
        halt_total_q <= halt_total_q + STAT_W'(1);
      end
    end
  end

  assign bus.halt_b     = halt_b_q;
  assign bus.halt_start = halt_start_q;
  assign bus.halt_end   = halt_end_q;
  assign bus.done       = done_q;
  assign bus.halt_total = halt_total_q;

endmodule
